// File: rtl/picobello_eoc_responder_if.sv
// Register-bus interface of the picobello EOC responder.
// Zero-wait-state request/response bus: the slave answers in the request cycle.
//   valid  master->slave  request valid
//   write  master->slave  1 = write, 0 = read
//   addr   master->slave  byte address, word aligned
//   wdata  master->slave  write data
//   wstrb  master->slave  byte strobes
//   ready  slave->master  request accepted (same cycle as valid)
//   rdata  slave->master  read data, valid with ready
//   error  slave->master  unmapped address or illegal access
interface picobello_eoc_responder_if #(
    parameter int unsigned AddrWidth = 8
) ();

    logic                 valid;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 ready;
    logic [31:0]          rdata;
    logic                 error;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output ready, rdata, error
    );

endinterface

// File: rtl/picobello_eoc_responder.sv
// Device-side end-of-computation (EOC) responder.
// Host software writes its return code over the register bus, clusters report completion
// through cluster_done_i; once armed, the block raises a sticky eoc_o with the latched
// exit code and a single-cycle eoc_irq_o on entry to DONE.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous reset, active low
//   reg_bus         register-bus slave (see picobello_eoc_responder_if)
//   cluster_done_i  per-cluster done pulses, OR'd into DONE_MASK
//   eoc_o           computation finished (level, sticky until CTRL.clear)
//   exit_code_o     latched exit code
//   eoc_irq_o       one-cycle pulse in the first DONE cycle
//
// Register map (byte addresses):
//   0x00 EOC       W: needs wstrb=4'hF; wdata[0]=done, wdata[31:1]=code. R: {exit_code, eoc}
//   0x04 DONE_MASK W1S (byte strobes honoured), R: mask
//   0x08 EXPECT    RW (byte strobes honoured)
//   0x0C STATUS    RO: [0]=eoc [1]=all_done [2]=timeout [4:3]=state; writes -> error
//   0x10 CTRL      WO (byte 0 strobe): [0]=arm [1]=clear; reads return 0
//   other          error, rdata=0
// State encoding in STATUS[4:3]: 0=IDLE 1=ARMED 2=WAIT_CLUSTERS 3=DONE.
//
// Optional feature: define PB_EOC_TIMEOUT_EN to enable a watchdog that forces DONE with
// exit code 31'h7FFF_FFFF after TimeoutCycles cycles in ARMED/WAIT_CLUSTERS.
module picobello_eoc_responder #(
    parameter int unsigned NumClusters   = 16,
    parameter int unsigned AddrWidth     = 8,
    parameter int unsigned TimeoutCycles = 32'd16777216
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    picobello_eoc_responder_if.slave reg_bus,
    input  logic [NumClusters-1:0] cluster_done_i,
    output logic                   eoc_o,
    output logic [30:0]            exit_code_o,
    output logic                   eoc_irq_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [AddrWidth-1:0] AddrEoc    = AddrWidth'(32'h00);
    localparam logic [AddrWidth-1:0] AddrMask   = AddrWidth'(32'h04);
    localparam logic [AddrWidth-1:0] AddrExpect = AddrWidth'(32'h08);
    localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'(32'h0C);
    localparam logic [AddrWidth-1:0] AddrCtrl   = AddrWidth'(32'h10);

    logic [1:0]             state_q, state_d;
    logic [NumClusters-1:0] done_mask_q, done_mask_d;
    logic [NumClusters-1:0] expect_q, expect_d;
    logic [30:0]            exit_code_q, exit_code_d;
    logic                   irq_q, irq_d;
    logic                   timeout_flag;

    logic sel_eoc, sel_mask, sel_expect, sel_status, sel_ctrl;
    logic wr_req, strb_full;
    logic eoc_wr, ctrl_wr, do_arm, do_clear;
    logic all_done, all_done_post;
    logic [31:0]            byte_mask;
    logic [31:0]            wdata_masked;
    logic [NumClusters-1:0] w1s_bits;

    // ---------------------------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------------------------
    always_comb begin
        sel_eoc      = (reg_bus.addr == AddrEoc);
        sel_mask     = (reg_bus.addr == AddrMask);
        sel_expect   = (reg_bus.addr == AddrExpect);
        sel_status   = (reg_bus.addr == AddrStatus);
        sel_ctrl     = (reg_bus.addr == AddrCtrl);
        wr_req       = reg_bus.valid & reg_bus.write;
        strb_full    = (reg_bus.wstrb == 4'hF);
        byte_mask    = {{8{reg_bus.wstrb[3]}}, {8{reg_bus.wstrb[2]}},
                        {8{reg_bus.wstrb[1]}}, {8{reg_bus.wstrb[0]}}};
        wdata_masked = reg_bus.wdata & byte_mask;
        eoc_wr       = wr_req & sel_eoc & strb_full;
        ctrl_wr      = wr_req & sel_ctrl & reg_bus.wstrb[0];
        do_arm       = ctrl_wr & reg_bus.wdata[0];
        do_clear     = ctrl_wr & reg_bus.wdata[1];
        w1s_bits     = (wr_req & sel_mask) ? wdata_masked[NumClusters-1:0] : '0;
    end

    assign all_done = ((done_mask_q & expect_q) == expect_q);

    // ---------------------------------------------------------------------------------------
    // Bus response (combinational, zero wait states)
    // ---------------------------------------------------------------------------------------
    assign reg_bus.ready = reg_bus.valid;

    always_comb begin
        reg_bus.rdata = '0;
        reg_bus.error = 1'b0;
        if (reg_bus.valid) begin
            if (sel_eoc) begin
                if (reg_bus.write) reg_bus.error = ~strb_full;
                else               reg_bus.rdata = {exit_code_q, eoc_o};
            end else if (sel_mask) begin
                if (!reg_bus.write) reg_bus.rdata = 32'(done_mask_q);
            end else if (sel_expect) begin
                if (!reg_bus.write) reg_bus.rdata = 32'(expect_q);
            end else if (sel_status) begin
                if (reg_bus.write) reg_bus.error = 1'b1;
                else reg_bus.rdata = {27'd0, state_q, timeout_flag, all_done, eoc_o};
            end else if (sel_ctrl) begin
                reg_bus.rdata = '0;
            end else begin
                reg_bus.error = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Watchdog (optional)
    // ---------------------------------------------------------------------------------------
`ifdef PB_EOC_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        cnt_run;
    logic        cnt_expired;

    assign cnt_run      = (state_q == StArmed) || (state_q == StWait);
    assign cnt_expired  = cnt_run && (cnt_q == 32'(TimeoutCycles - 1));
    assign timeout_flag = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(32'(TimeoutCycles));
    assign timeout_flag       = 1'b0;
`endif

    // ---------------------------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        done_mask_d = done_mask_q | cluster_done_i | w1s_bits;
        expect_d    = expect_q;
        if (wr_req && sel_expect) begin
            expect_d = (expect_q & ~byte_mask[NumClusters-1:0]) |
                       wdata_masked[NumClusters-1:0];
        end
        // The EOC decision sees the mask including this cycle's cluster/W1S sets.
        all_done_post = ((done_mask_d & expect_q) == expect_q);

        case (state_q)
            StIdle: begin
                if (do_arm) state_d = StArmed;
            end
            StArmed: begin
                if (eoc_wr && reg_bus.wdata[0]) begin
                    exit_code_d = reg_bus.wdata[31:1];
                    state_d     = all_done_post ? StDone : StWait;
                end
            end
            StWait: begin
                if (all_done) state_d = StDone;
            end
            default: ;
        endcase

`ifdef PB_EOC_TIMEOUT_EN
        timeout_d = timeout_q;
        cnt_d     = cnt_run ? cnt_q + 32'd1 : '0;
        // A normal transition in the expiry cycle wins over the watchdog.
        if (cnt_expired && (state_d == state_q)) begin
            state_d     = StDone;
            exit_code_d = 31'h7FFF_FFFF;
            timeout_d   = 1'b1;
        end
`endif

        // Clear overrides everything else, including a simultaneous arm.
        if (do_clear) begin
            state_d     = StIdle;
            done_mask_d = '0;
            exit_code_d = '0;
`ifdef PB_EOC_TIMEOUT_EN
            timeout_d   = 1'b0;
            cnt_d       = '0;
`endif
        end

        irq_d = (state_d == StDone) && (state_q != StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            done_mask_q <= '0;
            expect_q    <= '0;
            exit_code_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            expect_q    <= expect_d;
            exit_code_q <= exit_code_d;
            irq_q       <= irq_d;
        end
    end

    assign eoc_o       = (state_q == StDone);
    assign exit_code_o = exit_code_q;
    assign eoc_irq_o   = irq_q;

endmodule
